pipe_id_ex: RTL and testbench

PIPE_ID_EX -- requirements
Module: pipe_id_ex

---
 rtl/pipe_id_ex.sv | 125 ++++++++++++
 tb/tb_pipe_id_ex.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_id_ex.sv
// ID/EX pipeline register: carries decoded control and operands into EX,
// turns bubbles/flushes into NOPs and counts them with a saturating counter.
module pipe_id_ex #(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             hold_i,
    input  logic             bubble_i,
    input  logic             flush_i,
    input  logic             MemWrite_i,
    input  logic             MemRead_i,
    input  logic             MemToReg_i,
    input  logic             ALUSrc_i,
    input  logic             RegWrite_i,
    input  logic [1:0]       ALUOp_i,
    input  logic [31:0]      RS1data_i,
    input  logic [31:0]      RS2data_i,
    input  logic [31:0]      Imm_i,
    input  logic [31:0]      PC_i,
    input  logic [9:0]       Funct_i,
    input  logic [4:0]       RS1addr_i,
    input  logic [4:0]       RS2addr_i,
    input  logic [4:0]       RDaddr_i,
    output logic             MemWrite_o,
    output logic             MemRead_o,
    output logic             MemToReg_o,
    output logic             ALUSrc_o,
    output logic             RegWrite_o,
    output logic [1:0]       ALUOp_o,
    output logic [31:0]      RS1data_o,
    output logic [31:0]      RS2data_o,
    output logic [31:0]      Imm_o,
    output logic [31:0]      PC_o,
    output logic [9:0]       Funct_o,
    output logic [4:0]       RS1addr_o,
    output logic [4:0]       RS2addr_o,
    output logic [4:0]       RDaddr_o,
    output logic             Valid_o,
    output logic [CNT_W-1:0] EvtCnt_o
);

    logic             r_memwrite, r_memread, r_memtoreg, r_alusrc, r_regwrite, r_valid;
    logic [1:0]       r_aluop;
    logic [31:0]      r_rs1data, r_rs2data, r_imm, r_pc;
    logic [9:0]       r_funct;
    logic [4:0]       r_rs1addr, r_rs2addr, r_rdaddr;
    logic [CNT_W-1:0] r_evtcnt;

    logic w_kill;
    logic w_cnt_full;

    assign w_kill     = bubble_i | flush_i;
    assign w_cnt_full = &r_evtcnt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_memwrite <= 1'b0;
            r_memread  <= 1'b0;
            r_memtoreg <= 1'b0;
            r_alusrc   <= 1'b0;
            r_regwrite <= 1'b0;
            r_aluop    <= 2'b00;
            r_rs1data  <= '0;
            r_rs2data  <= '0;
            r_imm      <= '0;
            r_pc       <= '0;
            r_funct    <= '0;
            r_rs1addr  <= '0;
            r_rs2addr  <= '0;
            r_rdaddr   <= '0;
            r_valid    <= 1'b0;
            r_evtcnt   <= '0;
        end else if (!hold_i) begin
            // Operand fields always follow ID, even when the slot is squashed
            r_rs1data <= RS1data_i;
            r_rs2data <= RS2data_i;
            r_imm     <= Imm_i;
            r_pc      <= PC_i;
            r_funct   <= Funct_i;
            r_rs1addr <= RS1addr_i;
            r_rs2addr <= RS2addr_i;
            if (w_kill) begin
                r_memwrite <= 1'b0;
                r_memread  <= 1'b0;
                r_memtoreg <= 1'b0;
                r_alusrc   <= 1'b0;
                r_regwrite <= 1'b0;
                r_aluop    <= 2'b00;
                r_rdaddr   <= '0;
                r_valid    <= 1'b0;
                if (!w_cnt_full)
                    r_evtcnt <= r_evtcnt + 1'b1;
            end else begin
                r_memwrite <= MemWrite_i;
                r_memread  <= MemRead_i;
                r_memtoreg <= MemToReg_i;
                r_alusrc   <= ALUSrc_i;
                // x0 is never a real destination, so never let it forward
                r_regwrite <= RegWrite_i & (|RDaddr_i);
                r_aluop    <= ALUOp_i;
                r_rdaddr   <= RDaddr_i;
                r_valid    <= 1'b1;
            end
        end
    end

    assign MemWrite_o = r_memwrite;
    assign MemRead_o  = r_memread;
    assign MemToReg_o = r_memtoreg;
    assign ALUSrc_o   = r_alusrc;
    assign RegWrite_o = r_regwrite;
    assign ALUOp_o    = r_aluop;
    assign RS1data_o  = r_rs1data;
    assign RS2data_o  = r_rs2data;
    assign Imm_o      = r_imm;
    assign PC_o       = r_pc;
    assign Funct_o    = r_funct;
    assign RS1addr_o  = r_rs1addr;
    assign RS2addr_o  = r_rs2addr;
    assign RDaddr_o   = r_rdaddr;
    assign Valid_o    = r_valid;
    assign EvtCnt_o   = r_evtcnt;

endmodule

// File: tb/tb_pipe_id_ex.sv
// Bench for pipe_id_ex: directed vector table, counter saturation sequence on a
// narrow-counter instance, then random traffic against a rule-based model.
module tb_pipe_id_ex;

    typedef struct packed {
        logic        rst, hold, bubble, flush;
        logic        mw, mr, m2r, alusrc, rw;
        logic [1:0]  aluop;
        logic [31:0] rs1d, rs2d, imm, pc;
        logic [9:0]  funct;
        logic [4:0]  rs1a, rs2a, rd;
    } in_t;

    typedef struct packed {
        logic        mw, mr, m2r, alusrc, rw;
        logic [1:0]  aluop;
        logic [31:0] rs1d, rs2d, imm, pc;
        logic [9:0]  funct;
        logic [4:0]  rs1a, rs2a, rd;
        logic        valid;
        logic [15:0] cnt;
    } out_t;

    typedef struct {
        in_t         in;
        logic        e_rw;
        logic [1:0]  e_aluop;
        logic [4:0]  e_rd;
        logic        e_valid;
        logic [15:0] e_cnt;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    in_t  cur;
    out_t act, act4, exp_o;
    logic [3:0] cnt4;
    int   m_cnt4;
    int   n_tests = 0, n_fail = 0;

    logic        w_mw, w_mr, w_m2r, w_as, w_rw, w_v;
    logic [1:0]  w_aop;
    logic [31:0] w_r1d, w_r2d, w_imm, w_pc;
    logic [9:0]  w_fn;
    logic [4:0]  w_r1a, w_r2a, w_rd;
    logic [15:0] w_cnt;
    logic        x_mw, x_mr, x_m2r, x_as, x_rw, x_v;
    logic [1:0]  x_aop;
    logic [31:0] x_r1d, x_r2d, x_imm, x_pc;
    logic [9:0]  x_fn;
    logic [4:0]  x_r1a, x_r2a, x_rd;

    pipe_id_ex dut (
        .clk_i(clk), .rst_i(cur.rst), .hold_i(cur.hold), .bubble_i(cur.bubble), .flush_i(cur.flush),
        .MemWrite_i(cur.mw), .MemRead_i(cur.mr), .MemToReg_i(cur.m2r), .ALUSrc_i(cur.alusrc),
        .RegWrite_i(cur.rw), .ALUOp_i(cur.aluop), .RS1data_i(cur.rs1d), .RS2data_i(cur.rs2d),
        .Imm_i(cur.imm), .PC_i(cur.pc), .Funct_i(cur.funct), .RS1addr_i(cur.rs1a),
        .RS2addr_i(cur.rs2a), .RDaddr_i(cur.rd),
        .MemWrite_o(w_mw), .MemRead_o(w_mr), .MemToReg_o(w_m2r), .ALUSrc_o(w_as), .RegWrite_o(w_rw),
        .ALUOp_o(w_aop), .RS1data_o(w_r1d), .RS2data_o(w_r2d), .Imm_o(w_imm), .PC_o(w_pc),
        .Funct_o(w_fn), .RS1addr_o(w_r1a), .RS2addr_o(w_r2a), .RDaddr_o(w_rd), .Valid_o(w_v),
        .EvtCnt_o(w_cnt)
    );

    pipe_id_ex #(.CNT_W(4)) dut4 (
        .clk_i(clk), .rst_i(cur.rst), .hold_i(cur.hold), .bubble_i(cur.bubble), .flush_i(cur.flush),
        .MemWrite_i(cur.mw), .MemRead_i(cur.mr), .MemToReg_i(cur.m2r), .ALUSrc_i(cur.alusrc),
        .RegWrite_i(cur.rw), .ALUOp_i(cur.aluop), .RS1data_i(cur.rs1d), .RS2data_i(cur.rs2d),
        .Imm_i(cur.imm), .PC_i(cur.pc), .Funct_i(cur.funct), .RS1addr_i(cur.rs1a),
        .RS2addr_i(cur.rs2a), .RDaddr_i(cur.rd),
        .MemWrite_o(x_mw), .MemRead_o(x_mr), .MemToReg_o(x_m2r), .ALUSrc_o(x_as), .RegWrite_o(x_rw),
        .ALUOp_o(x_aop), .RS1data_o(x_r1d), .RS2data_o(x_r2d), .Imm_o(x_imm), .PC_o(x_pc),
        .Funct_o(x_fn), .RS1addr_o(x_r1a), .RS2addr_o(x_r2a), .RDaddr_o(x_rd), .Valid_o(x_v),
        .EvtCnt_o(cnt4)
    );

    assign act  = '{w_mw, w_mr, w_m2r, w_as, w_rw, w_aop, w_r1d, w_r2d, w_imm, w_pc,
                    w_fn, w_r1a, w_r2a, w_rd, w_v, w_cnt};
    assign act4 = '{x_mw, x_mr, x_m2r, x_as, x_rw, x_aop, x_r1d, x_r2d, x_imm, x_pc,
                    x_fn, x_r1a, x_r2a, x_rd, x_v, {12'd0, cnt4}};

    // Build an input record; operand fields are derived from a seed
    function automatic in_t mk(bit rst, bit hold, bit bub, bit fl, bit [4:0] ctl,
                               bit [1:0] aluop, bit [4:0] rd, bit [31:0] seed);
        in_t v;
        v.rst = rst; v.hold = hold; v.bubble = bub; v.flush = fl;
        {v.mw, v.mr, v.m2r, v.alusrc, v.rw} = ctl;
        v.aluop = aluop; v.rd = rd;
        v.rs1d = seed; v.rs2d = seed ^ 32'hA5A5_5A5A; v.imm = seed + 32'd1; v.pc = seed << 2;
        v.funct = seed[9:0]; v.rs1a = seed[4:0]; v.rs2a = seed[9:5];
        return v;
    endfunction

    // Reference: what the EX slot should hold after an edge with inputs v
    task automatic model(input in_t v);
        if (v.rst) begin
            exp_o = '0;
            m_cnt4 = 0;
        end else if (!v.hold) begin
            exp_o.rs1d = v.rs1d; exp_o.rs2d = v.rs2d; exp_o.imm = v.imm; exp_o.pc = v.pc;
            exp_o.funct = v.funct; exp_o.rs1a = v.rs1a; exp_o.rs2a = v.rs2a;
            if (v.bubble || v.flush) begin
                {exp_o.mw, exp_o.mr, exp_o.m2r, exp_o.alusrc, exp_o.rw} = '0;
                exp_o.aluop = 2'b00; exp_o.rd = 5'd0; exp_o.valid = 1'b0;
                if (exp_o.cnt < 16'd65535) exp_o.cnt = exp_o.cnt + 16'd1;
                if (m_cnt4 < 15) m_cnt4 = m_cnt4 + 1;
            end else begin
                exp_o.mw = v.mw; exp_o.mr = v.mr; exp_o.m2r = v.m2r; exp_o.alusrc = v.alusrc;
                exp_o.rw = v.rw && (v.rd != 5'd0);
                exp_o.aluop = v.aluop; exp_o.rd = v.rd; exp_o.valid = 1'b1;
            end
        end
    endtask

    task automatic chk(input string name, input logic [199:0] a, input logic [199:0] e);
        n_tests++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, a, e);
        end
    endtask

    task automatic step(input in_t v, input string name);
        out_t e4;
        cur = v;
        @(posedge clk);
        model(v);
        #1;
        e4 = exp_o;
        e4.cnt = 16'(m_cnt4);
        chk({name, "/model"}, 200'(act), 200'(exp_o));
        chk({name, "/model4"}, 200'(act4), 200'(e4));
    endtask

    vec_t vt[12];

    initial begin
        exp_o = '0;
        m_cnt4 = 0;
        cur = '0;
        //        rst hld bub fl  {mw,mr,m2r,as,rw} aluop rd  seed
        vt[0]  = '{mk(1,1,1,1, 5'b11111, 2'b11, 5'd7,  32'hDEAD_BEEF), 0, 2'b00, 5'd0,  0, 16'd0};
        vt[1]  = '{mk(0,0,0,0, 5'b00001, 2'b10, 5'd3,  32'h0000_0021), 1, 2'b10, 5'd3,  1, 16'd0};
        vt[2]  = '{mk(0,0,0,0, 5'b01111, 2'b00, 5'd5,  32'h1000_0040), 1, 2'b00, 5'd5,  1, 16'd0};
        vt[3]  = '{mk(0,0,1,0, 5'b01111, 2'b00, 5'd5,  32'h1000_0040), 0, 2'b00, 5'd0,  0, 16'd1};
        vt[4]  = '{mk(0,1,0,1, 5'b10001, 2'b01, 5'd7,  32'h2222_0001), 0, 2'b00, 5'd0,  0, 16'd1};
        vt[5]  = '{mk(0,1,1,1, 5'b11111, 2'b10, 5'd8,  32'h3333_0002), 0, 2'b00, 5'd0,  0, 16'd1};
        vt[6]  = '{mk(0,1,0,1, 5'b00011, 2'b11, 5'd9,  32'h4444_0003), 0, 2'b00, 5'd0,  0, 16'd1};
        vt[7]  = '{mk(0,0,1,1, 5'b10001, 2'b10, 5'd9,  32'h5555_0004), 0, 2'b00, 5'd0,  0, 16'd2};
        vt[8]  = '{mk(0,0,0,0, 5'b00001, 2'b10, 5'd0,  32'h6666_0005), 0, 2'b10, 5'd0,  1, 16'd2};
        vt[9]  = '{mk(0,0,0,0, 5'b00001, 2'b10, 5'd31, 32'h7777_0006), 1, 2'b10, 5'd31, 1, 16'd2};
        vt[10] = '{mk(1,0,1,0, 5'b00001, 2'b10, 5'd4,  32'h8888_0007), 0, 2'b00, 5'd0,  0, 16'd0};
        vt[11] = '{mk(0,0,0,0, 5'b10011, 2'b01, 5'd12, 32'h9999_0008), 1, 2'b01, 5'd12, 1, 16'd0};

        for (int i = 0; i < 12; i++) begin
            step(vt[i].in, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d/table", i),
                200'({act.rw, act.aluop, act.rd, act.valid, act.cnt}),
                200'({vt[i].e_rw, vt[i].e_aluop, vt[i].e_rd, vt[i].e_valid, vt[i].e_cnt}));
        end

        // Narrow counter saturates at 15 while the wide one keeps counting
        step(mk(1,0,0,0, 5'b0, 2'b00, 5'd0, 32'h0), "sat_rst");
        for (int i = 0; i < 17; i++)
            step(mk(0,0,0,1, 5'b00001, 2'b10, 5'd6, 32'(i * 3 + 1)), $sformatf("sat%0d", i));
        chk("sat_cnt4", 200'(cnt4), 200'(4'd15));
        chk("sat_cnt16", 200'(act.cnt), 200'(16'd17));
        step(mk(1,1,0,0, 5'b11111, 2'b10, 5'd6, 32'hFFFF_FFFF), "rst_over_hold");
        chk("rst_over_hold/zero", 200'(act) | 200'(act4), 200'd0);

        for (int i = 0; i < 400; i++) begin
            in_t r;
            r.rst    = ($urandom_range(0, 49) == 0);
            r.hold   = ($urandom_range(0, 3) == 0);
            r.bubble = ($urandom_range(0, 4) == 0);
            r.flush  = ($urandom_range(0, 4) == 0);
            {r.mw, r.mr, r.m2r, r.alusrc, r.rw} = 5'($urandom);
            r.aluop = 2'($urandom);
            r.rs1d = $urandom; r.rs2d = $urandom; r.imm = $urandom; r.pc = $urandom;
            r.funct = 10'($urandom);
            r.rs1a = 5'($urandom); r.rs2a = 5'($urandom);
            r.rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            step(r, $sformatf("rnd%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
